// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer.
// Streams 64-bit operand words LSW first and chains the carry between
// words. Each accepted beat produces one registered result word behind
// a single-entry valid/ready output stage.
module mp_add_seq #(
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = $clog2(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             op_sub,
    input  logic             cin_init,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic             out_cout,
    output logic             out_last,
    output logic [CNT_W-1:0] out_idx,
    output logic             err,
    input  logic             err_clr
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic             carry_q, op_q;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             first, op, cin;
    logic [CNT_W-1:0] idx;
    logic [63:0]      b_eff;
    logic [64:0]      full;
    logic             forced, last_eff, err_ev;

    // The output register is the only buffer; it can refill in the same
    // cycle it drains, so the input stalls only on a held result.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: any operation end (real or forced) returns to IDLE;
    // an in_first beat mid-chain simply starts a fresh chain.
    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = last_eff ? IDLE : RUN;
    end

    // Beat datapath: pick chain context, add, classify protocol events
    always_comb begin
        first    = (state == IDLE) || in_first;
        op       = first ? op_sub : op_q;
        cin      = first ? (cin_init ^ op_sub) : carry_q;
        idx      = first ? '0 : cnt;
        b_eff    = op ? ~in_b : in_b;
        full     = {1'b0, in_a} + {1'b0, b_eff} + {64'd0, cin};
        forced   = (idx == CNT_W'(MAX_WORDS - 1)) && !in_last;
        last_eff = in_last || forced;
        // Restart mid-chain, continuation with no open chain, or overrun
        err_ev   = accept && (((state == RUN) && in_first) ||
                              ((state == IDLE) && !in_first) ||
                              forced);
    end

    // Output register and carry chain context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            carry_q   <= 1'b0;
            op_q      <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= full[63:0];
            out_cout  <= full[64];
            out_last  <= last_eff;
            out_idx   <= idx;
            carry_q   <= full[64];
            op_q      <= op;
            cnt       <= idx + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error; a new error event beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err <= 1'b0;
        else if (err_ev)  err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

endmodule
